// File: rtl/regfile_scoreboard.sv
// Read-after-write interlock for the decode-stage register file: tracks in-flight
// destinations through a fixed-latency pipeline, stalls dependent decodes, counts stalls.
module regfile_scoreboard #(
    parameter int DEPTH     = 3,
    parameter bit WB_BYPASS = 1'b0,
    parameter int LINK_REG  = 14,
    parameter int PC_REG    = 15,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [3:0]       dec_a1,
    input  logic             dec_a1_used,
    input  logic [3:0]       dec_a2,
    input  logic             dec_a2_used,
    input  logic [3:0]       dec_rd,
    input  logic             dec_rd_write,
    input  logic             dec_link,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [15:0]      pending,
    output logic             wb_valid,
    output logic             wb_rd_valid,
    output logic [3:0]       wb_rd,
    output logic             wb_link,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic       rd_valid;
        logic [3:0] rd;
        logic       link;
    } entry_t;

    localparam logic [3:0] LINK_IDX = 4'(LINK_REG);
    localparam logic [3:0] PC_IDX   = 4'(PC_REG);
    // With a write-before-read register file the writeback entry is already visible.
    localparam int CHK = WB_BYPASS ? DEPTH - 1 : DEPTH;

    entry_t stage_q [DEPTH];
    entry_t new_entry;
    logic   hazard;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pending = '0;
        for (int i = 0; i < CHK; i++) begin
            if (stage_q[i].valid && stage_q[i].rd_valid) pending[stage_q[i].rd] = 1'b1;
            if (stage_q[i].valid && stage_q[i].link)     pending[LINK_IDX]      = 1'b1;
        end
        pending[PC_IDX] = 1'b0;
    end

    assign hazard = (dec_a1_used && (dec_a1 != PC_IDX) && pending[dec_a1])
                 || (dec_a2_used && (dec_a2 != PC_IDX) && pending[dec_a2]);
    assign stall  = dec_valid &&  hazard && !flush;
    assign issue  = dec_valid && !hazard && !flush;

    always_comb begin
        new_entry.valid    = 1'b1;
        new_entry.rd_valid = dec_rd_write && (dec_rd != PC_IDX);
        new_entry.rd       = dec_rd;
        new_entry.link     = dec_link;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the stages are control state, not storage; a stale valid bit would stall decode.
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking, so each stage takes its neighbour's pre-edge value.
            stage_q[0] <= issue ? new_entry : '0;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            // A taken branch kills the youngest in-flight instruction as it advances.
            if (flush) stage_q[1] <= '0;
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign wb_valid    = stage_q[DEPTH-1].valid;
    assign wb_rd_valid = stage_q[DEPTH-1].rd_valid;
    assign wb_rd       = stage_q[DEPTH-1].rd;
    assign wb_link     = stage_q[DEPTH-1].link;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: three instances share stimulus
// (DEPTH=3 without bypass, with bypass, and with a 4-bit stall counter).
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_a1_used, dec_a2_used, dec_rd_write, dec_link, flush;
    logic [3:0]  dec_a1, dec_a2, dec_rd;

    logic        stall0, issue0, wb_valid0, wb_rd_valid0, wb_link0;
    logic [15:0] pending0;
    logic [3:0]  wb_rd0;
    logic [15:0] stall_cnt0;

    logic        stall1, issue1, wb_valid1, wb_rd_valid1, wb_link1;
    logic [15:0] pending1;
    logic [3:0]  wb_rd1;
    logic [15:0] stall_cnt1;

    logic        stall2, issue2, wb_valid2, wb_rd_valid2, wb_link2;
    logic [15:0] pending2;
    logic [3:0]  wb_rd2;
    logic [3:0]  stall_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DEPTH(3), .WB_BYPASS(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_a1(dec_a1), .dec_a1_used(dec_a1_used), .dec_a2(dec_a2), .dec_a2_used(dec_a2_used),
        .dec_rd(dec_rd), .dec_rd_write(dec_rd_write), .dec_link(dec_link), .flush(flush),
        .stall(stall0), .issue(issue0), .pending(pending0), .wb_valid(wb_valid0),
        .wb_rd_valid(wb_rd_valid0), .wb_rd(wb_rd0), .wb_link(wb_link0), .stall_cnt(stall_cnt0)
    );

    regfile_scoreboard #(.DEPTH(3), .WB_BYPASS(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_a1(dec_a1), .dec_a1_used(dec_a1_used), .dec_a2(dec_a2), .dec_a2_used(dec_a2_used),
        .dec_rd(dec_rd), .dec_rd_write(dec_rd_write), .dec_link(dec_link), .flush(flush),
        .stall(stall1), .issue(issue1), .pending(pending1), .wb_valid(wb_valid1),
        .wb_rd_valid(wb_rd_valid1), .wb_rd(wb_rd1), .wb_link(wb_link1), .stall_cnt(stall_cnt1)
    );

    regfile_scoreboard #(.DEPTH(3), .WB_BYPASS(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_a1(dec_a1), .dec_a1_used(dec_a1_used), .dec_a2(dec_a2), .dec_a2_used(dec_a2_used),
        .dec_rd(dec_rd), .dec_rd_write(dec_rd_write), .dec_link(dec_link), .flush(flush),
        .stall(stall2), .issue(issue2), .pending(pending2), .wb_valid(wb_valid2),
        .wb_rd_valid(wb_rd_valid2), .wb_rd(wb_rd2), .wb_link(wb_link2), .stall_cnt(stall_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic [3:0] a1, input logic a1u,
                           input logic [3:0] a2, input logic a2u,
                           input logic [3:0] rd, input logic rdw, input logic lnk);
        dec_valid    = v;
        dec_a1       = a1;
        dec_a1_used  = a1u;
        dec_a2       = a2;
        dec_a2_used  = a2u;
        dec_rd       = rd;
        dec_rd_write = rdw;
        dec_link     = lnk;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        flush = 1'b0;
        set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Reset state, observed while rst is still high.
        rst = 1'b1;
        tick();
        set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        check("rst_pending",   pending0,     32'h0);
        check("rst_stall",     stall0,       32'h0);
        check("rst_issue",     issue0,       32'h1);
        check("rst_wb_valid",  wb_valid0,    32'h0);
        check("rst_wb_rdv",    wb_rd_valid0, 32'h0);
        check("rst_wb_rd",     wb_rd0,       32'h0);
        check("rst_wb_link",   wb_link0,     32'h0);
        check("rst_stall_cnt", stall_cnt0,   32'h0);

        // Basic RAW: producer rd=3, dependent reads a1=3.
        do_reset();
        set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        #1 check("raw_issue_prod", issue0, 32'h1);
        tick();
        set_dec(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("raw_stall_nobyp", stall0,      32'(k <= 3));
            check("raw_stall_byp",   stall1,      32'(k <= 2));
            check("raw_pend3",       pending0[3], 32'(k <= 3));
            check("raw_wbv_nobyp",   wb_valid0,   32'(k == 3));
            check("raw_wbv_byp",     wb_valid1,   32'(k == 3));
            if (k == 3) check("raw_wb_rd", wb_rd0, 32'd3);
            if (k == 4) begin
                check("raw_issue_dep",   issue0,     32'h1);
                check("raw_cnt_nobyp",   stall_cnt0, 32'd3);
                check("raw_cnt_byp",     stall_cnt1, 32'd2);
            end
            tick();
        end

        // PC destination is never tracked.
        do_reset();
        set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0);
        #1 check("pc_issue_prod", issue0, 32'h1);
        tick();
        set_dec(1'b1, 4'd15, 1'b1, 4'd15, 1'b1, 4'd0, 1'b0, 1'b0);
        #1;
        check("pc_stall",   stall0,   32'h0);
        check("pc_issue",   issue0,   32'h1);
        check("pc_pending", pending0, 32'h0);
        tick();
        set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        #1;
        check("pc_wb_valid", wb_valid0,    32'h1);
        check("pc_wb_rdv",   wb_rd_valid0, 32'h0);
        check("pc_wb_rd",    wb_rd0,       32'd15);

        // Link write: rd=2 plus R14.
        do_reset();
        set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
        tick();
        set_dec(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        check("lnk_pending",  pending0, 32'h4004);
        check("lnk_r7_stall", stall0,   32'h0);
        check("lnk_r7_issue", issue0,   32'h1);
        tick();
        set_dec(1'b1, 4'd0, 1'b0, 4'd14, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            #1;
            check("lnk_stall", stall0, 32'(k <= 3));
            check("lnk_issue", issue0, 32'(k == 4));
            if (k == 3) begin
                check("lnk_pend_wb", pending0,     32'h4004);
                check("lnk_wb_link", wb_link0,     32'h1);
                check("lnk_wb_rdv",  wb_rd_valid0, 32'h1);
            end
            if (k == 4) check("lnk_pend_clr", pending0, 32'h0);
            tick();
        end

        // Flush kills rd=5 (youngest) but the older rd=6 still retires.
        do_reset();
        set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
        tick();
        set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        tick();
        set_dec(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        check("fl_issue",   issue0,   32'h0);
        check("fl_stall",   stall0,   32'h0);
        check("fl_pend_in", pending0, 32'h0060);
        tick();
        flush = 1'b0;
        set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            #1;
            check("fl_wb_valid", wb_valid0, 32'(k == 2));
            if (k == 2) begin
                check("fl_wb_rd",   wb_rd0,   32'd6);
                check("fl_pending", pending0, 32'h0040);
            end else begin
                check("fl_pend_idle", pending0, 32'h0);
            end
            tick();
        end

        // Saturation: a self-dependent instruction stalls 3 of every 4 cycles.
        do_reset();
        set_dec(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
        repeat (20) tick();
        #1 check("sat_cnt_at15", stall_cnt2, 32'd15);
        repeat (10) tick();
        #1;
        check("sat_cnt_held", stall_cnt2, 32'd15);
        check("sat_cnt_wide", stall_cnt0, 32'd22);

        // Fill three entries, then reset mid-flight.
        set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
        repeat (3) tick();
        #1;
        check("mid_pending", pending0,   32'h0200);
        check("mid_wb_rd",   wb_rd0,     32'd9);
        check("mid_cnt",     stall_cnt2, 32'd15);
        do_reset();
        #1;
        check("post_rst_pending", pending0,   32'h0);
        check("post_rst_wbv",     wb_valid0,  32'h0);
        check("post_rst_cnt",     stall_cnt2, 32'h0);
        check("post_rst_cnt0",    stall_cnt0, 32'h0);
        tick();
        #1 check("post_rst_wbv2", wb_valid0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Read-after-write interlock controller for the decode-stage register file (16 x 32-bit; R15 = PC, R14 = link).
- Tracks in-flight destination registers through a fixed-latency in-order pipeline from execute to writeback.
- Stalls decode when a source operand is still pending, and cancels in-flight work on a pipeline flush.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- DEPTH, 3: pipeline stages from issue to register-file write, inclusive (legal 2..8).
- WB_BYPASS, 0: 1 = the register file writes before it reads in the same cycle, so the final-stage entry is excluded from hazard checks.
- LINK_REG, 14: register written by link instructions.
- PC_REG, 15: PC alias; never tracked, never stalls.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  valid instruction in decode.
- dec_a1  in  4  source register A1.
- dec_a1_used  in  1  A1 is read.
- dec_a2  in  4  source register A2.
- dec_a2_used  in  1  A2 is read.
- dec_rd  in  4  destination register.
- dec_rd_write  in  1  instruction writes dec_rd.
- dec_link  in  1  instruction also writes LINK_REG.
- flush  in  1  taken branch: kill decode and the youngest in-flight stage.
- stall  out  1  hold fetch/decode this cycle.
- issue  out  1  decode instruction advances this cycle.
- pending  out  16  scoreboard, one bit per register.
- wb_valid  out  1  entry in final stage.
- wb_rd_valid  out  1  final-stage entry writes wb_rd.
- wb_rd  out  4  final-stage destination.
- wb_link  out  1  final-stage entry writes LINK_REG.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Entry format: {valid, rd_valid, rd[3:0], link}. Entries sit in a shift register stage[0..DEPTH-1].
- stage[0] holds the instruction in execute; stage[DEPTH-1] is at writeback.
- pending[r] = OR over checked stages of (valid & rd_valid & rd==r) | (valid & link & r==LINK_REG).
  - Checked stages: 0..DEPTH-1 when WB_BYPASS=0; 0..DEPTH-2 when WB_BYPASS=1.
  - pending[PC_REG] is forced to 0.
- The rd_valid bit of an issued entry is dec_rd_write & (dec_rd != PC_REG). PC writes are handled by flush, not the scoreboard.
- hazard = (dec_a1_used & dec_a1!=PC_REG & pending[dec_a1]) | (dec_a2_used & dec_a2!=PC_REG & pending[dec_a2]).
- stall = dec_valid & hazard & !flush. This is combinational from registered state and inputs, with no added latency.
- issue = dec_valid & !hazard & !flush.
- Each edge, priority rst > flush > normal:
  - rst: every stage becomes empty; stall_cnt <= 0.
  - flush: stage[0] <= empty; stage[1] <= empty (old stage[0] is discarded); stage[i] <= stage[i-1] for i >= 2.
  - normal: stage[0] <= issue ? new entry : empty; stage[i] <= stage[i-1].
- An entry leaving stage[DEPTH-1] is retired. Its pending bit drops on the same edge, unless another in-flight entry targets the same register.
- Duplicate destinations in flight (WAW) are legal. A pending bit clears only when no checked stage still targets that register.
- wb_* outputs come straight from stage[DEPTH-1]. After reset: wb_valid=0, wb_rd_valid=0, wb_rd=0, wb_link=0.
- stall_cnt increments on each edge where stall=1. It holds at 2^CNT_W-1 and does not wrap.
- Reset values: pending=0, stall=0 (no entries), issue=dec_valid & !flush, stall_cnt=0.
- Reset mid-operation discards all in-flight entries. No writeback is reported afterwards.
- Stall latency to a dependent instruction after its producer issues:
  - WB_BYPASS=0: DEPTH cycles.
  - WB_BYPASS=1: DEPTH-1 cycles.

Test Plan:
- DEPTH=3, WB_BYPASS=0: issue rd=3 write; next cycle decode reads a1=3 -> stall=1 for exactly 3 cycles, pending[3]=1 throughout, wb_valid=1 with wb_rd=3 in the 3rd, issue=1 in the 4th, stall_cnt=3.
- Same with WB_BYPASS=1 -> stall for 2 cycles, stall_cnt=2.
- Issue dec_rd=15 write, then read a1=15 and a2=15 -> stall=0, pending=0, wb_rd_valid=0 at writeback.
- Link: issue dec_rd_write=1, rd=2, dec_link=1 -> pending=0x4004. Next read a2=14 -> stall 3 cycles. Read a1=7 issues immediately.
- Flush: issue rd=5; next cycle flush=1 with dec_valid reading a1=5 -> issue=0, stall=0. Following cycle pending[5]=0; no wb_valid for rd=5 ever appears.
- CNT_W=4 with a held hazard -> stall_cnt saturates at 15. Then assert rst with 3 entries in flight -> next cycle pending=0, wb_valid=0, stall_cnt=0.
